// File: rtl/layer3_feeder_pkg.sv
// Shared definitions for the layer-3 weight feeder.
// Holds the FSM state enum, the default word width derived from
// LAYER3_WEIGHT_INPUT_LENGTH, the default address width and the default
// delay-line depth the feeder drains after the last word.
package layer3_feeder_pkg;

    localparam int unsigned LAYER3_WEIGHT_INPUT_LENGTH = 128;
    localparam int unsigned FEEDER_DATA_W              = LAYER3_WEIGHT_INPUT_LENGTH;
    localparam int unsigned FEEDER_ADDR_W              = 10;
    localparam int unsigned FEEDER_DEPTH               = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/layer3_weight_feeder_if.sv
// Bundle of the feeder's controller, weight-buffer and delay-line signals.
//   start, base_addr, word_count : run request from the layer-3 controller
//   rd_en, rd_addr, rd_data      : one-cycle-latency weight buffer read port
//   out_data, out_valid          : word stream into the delay-line input
//   busy, done                   : run status back to the controller
// master = the feeder, slave = its environment.
interface layer3_weight_feeder_if
    import layer3_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = FEEDER_DATA_W,
    parameter int unsigned ADDR_W = FEEDER_ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   word_count;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              done;

    modport master (
        input  start, base_addr, word_count, rd_data,
        output rd_en, rd_addr, out_data, out_valid, busy, done
    );

    modport slave (
        output start, base_addr, word_count, rd_data,
        input  rd_en, rd_addr, out_data, out_valid, busy, done
    );

endinterface

// File: rtl/feeder_down_counter.sv
// Loadable down-counter with a zero flag; saturates at zero.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over i_dec)
//   i_dec      : decrement by one when non-zero
//   o_zero     : count is zero
module feeder_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/layer3_weight_feeder.sv
// Layer-3 weight feeder: reads word_count words starting at base_addr from
// the weight buffer (one-cycle read latency), streams them one per cycle
// into the weight delay line, drains for the line depth, then pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : layer3_weight_feeder_if.master (controller, buffer, delay line)
// Build option LAYER3_FEEDER_ZERO_FILL_EN: when defined, out_data is forced
// to zero whenever out_valid is low; otherwise it holds the last word.
module layer3_weight_feeder
    import layer3_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = FEEDER_DATA_W,
    parameter int unsigned ADDR_W = FEEDER_ADDR_W,
    parameter int unsigned DEPTH  = FEEDER_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    layer3_weight_feeder_if.master  bus
);

    localparam int unsigned DRAIN_W = $clog2(DEPTH + 2) + 1;

    feeder_state_e     r_state;
    feeder_state_e     w_state_d;
    logic              w_accept;
    logic              w_words_zero;
    logic              w_drain_zero;
    logic [ADDR_W:0]   w_word_load;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;

    assign w_accept    = (r_state == IDLE) && bus.start;
    // Counter holds the strobes still owed after the current one.
    assign w_word_load = bus.word_count - (ADDR_W + 1)'(1);

    feeder_down_counter #(
        .WIDTH (ADDR_W + 1)
    ) u_word_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && (bus.word_count != '0)),
        .i_load_val (w_word_load),
        .i_dec      ((r_state == READ) && !w_words_zero),
        .o_zero     (w_words_zero)
    );

    // DRAIN lasts DEPTH+2 cycles; the count is loaded on the last READ edge
    // and exits on zero, so the loaded value is the cycles remaining after
    // the first drain cycle.
    feeder_down_counter #(
        .WIDTH (DRAIN_W)
    ) u_drain_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     ((r_state == READ) && w_words_zero),
        .i_load_val (DRAIN_W'(DEPTH + 1)),
        .i_dec      ((r_state == DRAIN) && !w_drain_zero),
        .o_zero     (w_drain_zero)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE:    if (bus.start) w_state_d = (bus.word_count != '0) ? READ : DONE;
            READ:    if (w_words_zero) w_state_d = DRAIN;
            DRAIN:   if (w_drain_zero) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_vld    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_rd_en <= (w_state_d == READ);
            if (w_accept) begin
                r_rd_addr <= bus.base_addr;
            end else if ((r_state == READ) && !w_words_zero) begin
                r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end
            r_rd_vld    <= r_rd_en;
            r_out_valid <= r_rd_vld;
`ifdef LAYER3_FEEDER_ZERO_FILL_EN
            r_out_data  <= r_rd_vld ? bus.rd_data : '0;
`else
            if (r_rd_vld) begin
                r_out_data <= bus.rd_data;
            end
`endif
            r_busy <= (w_state_d == READ) || (w_state_d == DRAIN);
            r_done <= (w_state_d == DONE);
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule

// File: tb/tb_layer3_weight_feeder.sv
// Scoreboard bench for layer3_weight_feeder: expected read addresses, output
// words, delay-line exits and done pulses are queued with their cycle when a
// run is started and popped as the DUT (or delay-line model) produces them.
module tb_layer3_weight_feeder;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 12;
    localparam int LIMIT  = 1500;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    exp_t q_addr[$];
    exp_t q_data[$];
    exp_t q_dl[$];
    int   q_done[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    logic [DATA_W-1:0] tb_last = '0;
    exp_t m_e;
    int   m_c;

    logic [DATA_W-1:0] dl_d [DEPTH];
    logic              dl_v [DEPTH];

    layer3_weight_feeder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    layer3_weight_feeder #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight buffer: data = address, garbage when not read.
    always @(posedge clk) begin
        if (rst) bus.rd_data <= '0;
        else     bus.rd_data <= bus.rd_en ? DATA_W'(bus.rd_addr) : {4{32'hDEADBEEF}};
    end

    // Delay-line model, reset together with the feeder.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                dl_v[i] <= 1'b0;
                dl_d[i] <= '0;
            end
        end else begin
            dl_v[0] <= bus.out_valid;
            dl_d[0] <= bus.out_data;
            for (int i = 1; i < DEPTH; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_d[i] <= dl_d[i-1];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                            input logic [DATA_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rd_en) begin
                if (q_addr.size() == 0) begin
                    check_eq("rd_en_unexp", DATA_W'(bus.rd_en), DATA_W'(0));
                end else begin
                    m_e = q_addr.pop_front();
                    check_eq("rd_addr", DATA_W'(bus.rd_addr), m_e.val);
                    check_eq("rd_cyc", DATA_W'(cyc), DATA_W'(m_e.cyc));
                end
            end
            if (bus.out_valid) begin
                if (q_data.size() == 0) begin
                    check_eq("out_valid_unexp", DATA_W'(bus.out_valid), DATA_W'(0));
                end else begin
                    m_e = q_data.pop_front();
                    check_eq("out_data", bus.out_data, m_e.val);
                    check_eq("out_cyc", DATA_W'(cyc), DATA_W'(m_e.cyc));
                    tb_last = m_e.val;
                end
            end else begin
`ifdef LAYER3_FEEDER_ZERO_FILL_EN
                check_eq("out_data_idle", bus.out_data, '0);
`else
                check_eq("out_data_idle", bus.out_data, tb_last);
`endif
            end
            if (bus.done) begin
                if (q_done.size() == 0) begin
                    check_eq("done_unexp", DATA_W'(bus.done), DATA_W'(0));
                end else begin
                    m_c = q_done.pop_front();
                    check_eq("done_cyc", DATA_W'(cyc), DATA_W'(m_c));
                end
            end
            if (dl_v[DEPTH-1]) begin
                if (q_dl.size() == 0) begin
                    check_eq("dl_unexp", DATA_W'(dl_v[DEPTH-1]), DATA_W'(0));
                end else begin
                    m_e = q_dl.pop_front();
                    check_eq("dl_data", dl_d[DEPTH-1], m_e.val);
                    check_eq("dl_cyc", DATA_W'(cyc), DATA_W'(m_e.cyc));
                end
            end
            check_eq("busy", DATA_W'(bus.busy), DATA_W'((cyc >= busy_lo) && (cyc <= busy_hi)));
        end
    end

    task automatic run(input logic [ADDR_W-1:0] base, input int n, output int t);
        logic [ADDR_W-1:0] a;
        @(posedge clk); #1;
        t              = cyc;
        bus.start      = 1'b1;
        bus.base_addr  = base;
        bus.word_count = (ADDR_W + 1)'(n);
        a = base;
        for (int k = 0; k < n; k++) begin
            q_addr.push_back('{t + 1 + k, DATA_W'(a)});
            q_data.push_back('{t + 3 + k, DATA_W'(a)});
            q_dl.push_back('{t + 3 + k + DEPTH, DATA_W'(a)});
            a = a + ADDR_W'(1);
        end
        if (n > 0) begin
            busy_lo = t + 1;
            busy_hi = t + n + DEPTH + 2;
            q_done.push_back(t + n + DEPTH + 3);
        end else begin
            q_done.push_back(t + 1);
        end
        @(posedge clk); #1;
        // Scramble the request so only the latched copy can be used.
        bus.start      = 1'b0;
        bus.base_addr  = ~base;
        bus.word_count = (ADDR_W + 1)'(7);
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk); #1;
            if (q_addr.size() == 0 && q_data.size() == 0 && q_dl.size() == 0 &&
                q_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check_eq(tag, DATA_W'(0), DATA_W'(1));
            q_addr.delete(); q_data.delete(); q_dl.delete(); q_done.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rd_en"}, DATA_W'(bus.rd_en), '0);
        check_eq({tag, "_rd_addr"}, DATA_W'(bus.rd_addr), '0);
        check_eq({tag, "_out_data"}, bus.out_data, '0);
        check_eq({tag, "_out_valid"}, DATA_W'(bus.out_valid), '0);
        check_eq({tag, "_busy"}, DATA_W'(bus.busy), '0);
        check_eq({tag, "_done"}, DATA_W'(bus.done), '0);
    endtask

    initial begin
        int t;
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.word_count = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        mon_en = 1'b1;

        // Normal run; done at T+19, last word leaves delay line at T+18.
        run(10'h010, 4, t);
        wait_idle("timeout_normal");

        // Back-to-back: wrap-around run, then an empty run.
        run(10'h3FE, 3, t);
        wait_idle("timeout_wrap");
        run(10'h123, 0, t);
        wait_idle("timeout_empty");

        // Starts during READ and DRAIN must be ignored.
        run(10'h100, 8, t);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 10'h2AA; bus.word_count = 11'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.word_count = 11'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle("timeout_ignored");

        // Reset in cycle T+3 of a 10-word run.
        run(10'h050, 10, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_addr.delete(); q_data.delete(); q_dl.delete(); q_done.delete();
        busy_lo = 1; busy_hi = 0;
        tb_last = '0;
        @(negedge clk);
        check_all_zero("midrst");
        run(10'h020, 2, t);
        wait_idle("timeout_after_rst");

        // Full address space from a non-zero base.
        run(10'h155, 1024, t);
        wait_idle("timeout_full");
        check_eq("full_end_addr", DATA_W'(bus.rd_addr), DATA_W'(10'h154));

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
